// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: one bit position per clock, valid/ready on both sides.
// Optional rotate support via SEQ_SHIFT_ROTATE_EN (adds the rot input).
module seq_shift_unit #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amt,
    input  logic             dir,
    input  logic             arith,
`ifdef SEQ_SHIFT_ROTATE_EN
    input  logic             rot,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [AMT_W-1:0] count;
    logic             dir_q;
    logic             arith_q;
`ifdef SEQ_SHIFT_ROTATE_EN
    logic             rot_q;
`endif

    logic             fill;
    logic [WIDTH-1:0] step_data;
    logic             step_carry;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Next value of the working register for one SHIFT step.
    always_comb begin
        fill       = arith_q & data_out[WIDTH-1];
        step_data  = data_out;
        step_carry = carry_out;
        if (dir_q) begin
            step_data  = {fill, data_out[WIDTH-1:1]};
            step_carry = data_out[0];
        end else begin
            step_data  = {data_out[WIDTH-2:0], 1'b0};
            step_carry = data_out[WIDTH-1];
        end
`ifdef SEQ_SHIFT_ROTATE_EN
        if (rot_q) begin
            if (dir_q) begin
                step_data  = {data_out[0], data_out[WIDTH-1:1]};
                step_carry = data_out[0];
            end else begin
                step_data  = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
                step_carry = data_out[WIDTH-1];
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            data_out  <= '0;
            carry_out <= 1'b0;
            count     <= '0;
            dir_q     <= 1'b0;
            arith_q   <= 1'b0;
`ifdef SEQ_SHIFT_ROTATE_EN
            rot_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_out  <= data_in;
                        carry_out <= 1'b0;
                        count     <= amt;
                        dir_q     <= dir;
                        arith_q   <= arith;
`ifdef SEQ_SHIFT_ROTATE_EN
                        rot_q     <= rot;
`endif
                        state     <= (amt != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    data_out  <= step_data;
                    carry_out <= step_carry;
                    count     <= count - 1'b1;
                    if (count == AMT_W'(1))
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Randomized bench for seq_shift_unit against a shift-formula reference.
// Rotate cases are exercised only when SEQ_SHIFT_ROTATE_EN is defined.
module tb_seq_shift_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic [3:0]  amt;
    logic        dir;
    logic        arith;
    logic        rot;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_out;
    logic        carry_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_shift_unit #(.WIDTH(16), .AMT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .amt       (amt),
        .dir       (dir),
        .arith     (arith),
`ifdef SEQ_SHIFT_ROTATE_EN
        .rot       (rot),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .carry_out (carry_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Whole-operation reference: result of shifting/rotating by a bits.
    function automatic void model(input logic [15:0] d, input int a,
                                  input bit dr, input bit ar, input bit ro,
                                  output logic [15:0] r, output bit c);
        logic [31:0] x;
        logic [47:0] y;
        if (ro) begin
            if (dr) begin
                x = {d, d} >> a;
                r = x[15:0];
                c = r[15];
            end else begin
                x = {d, d} << a;
                r = x[31:16];
                c = r[0];
            end
        end else if (dr) begin
            y = {(ar ? {16{d[15]}} : 16'h0), d, 16'h0} >> a;
            r = y[31:16];
            c = y[15];
        end else begin
            x = {16'h0, d} << a;
            r = x[15:0];
            c = x[16];
        end
        if (a == 0) c = 1'b0;
    endfunction

    task automatic issue(input logic [15:0] d, input int a, input bit dr,
                         input bit ar, input bit ro, input int bp);
        logic [15:0] er;
        bit          ec;
        int          n;
        model(d, a, dr, ar, ro, er, ec);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        data_in  = d;
        amt      = 4'(a);
        dir      = dr;
        arith    = ar;
        rot      = ro;
        in_valid = 1'b1;
        @(negedge clk);
        n = 1;
        // Junk on the command inputs must be ignored once accepted.
        while (!out_valid && n < 40) begin
            data_in  = 16'($urandom);
            amt      = 4'($urandom);
            dir      = 1'($urandom);
            arith    = 1'($urandom);
            rot      = 1'($urandom);
            in_valid = 1'($urandom);
            check("busy_shift", 32'(busy), 32'd1);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("latency", 32'(n), 32'(a + 1));
        check("data", 32'(data_out), 32'(er));
        check("carry", 32'(carry_out), 32'(ec));
        check("in_ready_done", 32'(in_ready), 32'd0);
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'($urandom);
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(data_out), 32'(er));
            check("bp_carry", 32'(carry_out), 32'(ec));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_keep", 32'(data_out), 32'(er));
    endtask

    initial begin
        int seen;
        rst       = 1'b0;
        data_in   = '0;
        amt       = '0;
        dir       = 1'b0;
        arith     = 1'b0;
        rot       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        rst = 1'b1;

        issue(16'h0002, 1, 1, 0, 0, 0);
        issue(16'h000F, 2, 1, 0, 0, 0);
        issue(16'h000F, 2, 0, 0, 0, 0);
        issue(16'h8000, 3, 1, 1, 0, 0);
        issue(16'h8000, 3, 1, 0, 0, 0);
        issue(16'h1234, 0, 1, 1, 0, 1);
        issue(16'h0002, 1, 0, 0, 0, 5);
        issue(16'hFFFF, 15, 0, 0, 0, 0);
        issue(16'h8001, 15, 1, 1, 0, 2);
        issue(16'h4001, 15, 1, 0, 0, 0);
`ifdef SEQ_SHIFT_ROTATE_EN
        issue(16'h0001, 1, 1, 0, 1, 0);
        issue(16'h8001, 4, 0, 1, 1, 0);
`endif

        for (int k = 0; k < 40; k++) begin
            bit ro;
`ifdef SEQ_SHIFT_ROTATE_EN
            ro = 1'($urandom);
`else
            ro = 1'b0;
`endif
            issue(16'($urandom), int'($urandom_range(0, 15)),
                  1'($urandom), 1'($urandom), ro,
                  int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a long shift discards the result.
        @(negedge clk);
        data_in  = 16'h00FF;
        amt      = 4'd15;
        dir      = 1'b0;
        arith    = 1'b0;
        rot      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_data", 32'(data_out), 32'd0);
        check("mid_rst_carry", 32'(carry_out), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        out_ready = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_no_result", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
